// File: rtl/pong_sound_ctrl.sv
// Sound sequencer: turns one-clock game events into timed buzzer beeps.
// Beep length is counted in game_en ticks; the tone comes from the external square waves.
module pong_sound_ctrl #(
   parameter int CNT_W       = 8,
   parameter int PAD_TICKS   = 8,
   parameter int WALL_TICKS  = 4,
   parameter int SCORE_TICKS = 48,
   parameter int SCORE_SEG   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_en,
   input  logic       pad_hit,
   input  logic       wall_hit,
   input  logic       score_evt,
   input  logic       pad_tone,
   input  logic       wall_tone,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] snd_id
);

   // Encoding doubles as priority and as the snd_id value.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALL  = 2'd1,
      PAD   = 2'd2,
      SCORE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PAD_LD   = CNT_W'(PAD_TICKS);
   localparam logic [CNT_W-1:0] WALL_LD  = CNT_W'(WALL_TICKS);
   localparam logic [CNT_W-1:0] SCORE_LD = CNT_W'(SCORE_TICKS);
   localparam logic [CNT_W-1:0] SEG_LD   = CNT_W'(SCORE_SEG);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_tickCnt;
   logic [CNT_W-1:0] r_segCnt;
   logic             r_segSel;
   logic             r_buzzer;
   logic             r_busy;
   logic [1:0]       r_sndId;

   state_t           w_evtState;
   logic             w_accept;
   logic [CNT_W-1:0] w_loadVal;
   logic             w_toneMux;

   always_comb begin
      w_evtState = IDLE;
      if (score_evt)
         w_evtState = SCORE;
      else if (pad_hit)
         w_evtState = PAD;
      else if (wall_hit)
         w_evtState = WALL;
   end

   // Equal priority is accepted too, so a repeated event restarts its sound.
   assign w_accept = (w_evtState != IDLE) && (w_evtState >= r_state);

   always_comb begin
      w_loadVal = '0;
      case (w_evtState)
         WALL:    w_loadVal = WALL_LD;
         PAD:     w_loadVal = PAD_LD;
         SCORE:   w_loadVal = SCORE_LD;
         default: w_loadVal = '0;
      endcase
   end

   always_comb begin
      w_toneMux = 1'b0;
      case (r_state)
         WALL:    w_toneMux = wall_tone;
         PAD:     w_toneMux = pad_tone;
         SCORE:   w_toneMux = r_segSel ? pad_tone : wall_tone;
         default: w_toneMux = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tickCnt <= '0;
         r_segCnt  <= '0;
         r_segSel  <= 1'b0;
         r_buzzer  <= 1'b0;
         r_busy    <= 1'b0;
         r_sndId   <= 2'd0;
      end else begin
         r_buzzer <= w_toneMux & ~mute;
         if (w_accept) begin
            r_state   <= w_evtState;
            r_tickCnt <= w_loadVal;
            r_busy    <= 1'b1;
            r_sndId   <= w_evtState;
            if (w_evtState == SCORE) begin
               r_segCnt <= SEG_LD;
               r_segSel <= 1'b0;
            end
         end else if (game_en && (r_state != IDLE)) begin
            if (r_tickCnt > ONE) begin
               r_tickCnt <= r_tickCnt - ONE;
               // Segment counter only advances while the jingle is still running.
               if (r_state == SCORE) begin
                  if (r_segCnt > ONE) begin
                     r_segCnt <= r_segCnt - ONE;
                  end else begin
                     r_segCnt <= SEG_LD;
                     r_segSel <= ~r_segSel;
                  end
               end
            end else begin
               r_state   <= IDLE;
               r_tickCnt <= '0;
               r_segCnt  <= '0;
               r_segSel  <= 1'b0;
               r_busy    <= 1'b0;
               r_sndId   <= 2'd0;
            end
         end
      end
   end

   assign buzzer = r_buzzer;
   assign busy   = r_busy;
   assign snd_id = r_sndId;

endmodule

// File: tb/tb_pong_sound_ctrl.sv
// Scoreboard bench for pong_sound_ctrl: a tick-elapsed model predicts buzzer/busy/snd_id
// every clock, the prediction is queued at drive time and popped after the edge.
module tb_pong_sound_ctrl;

   localparam int PAD_TICKS   = 8;
   localparam int WALL_TICKS  = 4;
   localparam int SCORE_TICKS = 48;
   localparam int SCORE_SEG   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       game_en = 1'b0;
   logic       pad_hit = 1'b0;
   logic       wall_hit = 1'b0;
   logic       score_evt = 1'b0;
   logic       pad_tone = 1'b0;
   logic       wall_tone = 1'b0;
   logic       mute = 1'b0;
   logic       buzzer;
   logic       busy;
   logic [1:0] snd_id;

   int          total = 0;
   int          bad = 0;
   logic [3:0]  expQ[$];
   logic [31:0] cycCnt = '0;
   int          phase = 0;
   logic        muteLvl = 1'b0;
   string       curTag = "init";

   int mdlState = 0;
   int mdlRemain = 0;
   int mdlElapsed = 0;

   always #5 clk = ~clk;

   pong_sound_ctrl #(
      .CNT_W(8), .PAD_TICKS(PAD_TICKS), .WALL_TICKS(WALL_TICKS),
      .SCORE_TICKS(SCORE_TICKS), .SCORE_SEG(SCORE_SEG)
   ) dut (
      .clk(clk), .rst(rst), .game_en(game_en), .pad_hit(pad_hit), .wall_hit(wall_hit),
      .score_evt(score_evt), .pad_tone(pad_tone), .wall_tone(wall_tone), .mute(mute),
      .buzzer(buzzer), .busy(busy), .snd_id(snd_id)
   );

   task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d got{buz,busy,id}=%b expected=%b", tag, cycCnt, got, exp);
      end
   endtask

   function automatic int ticksFor(input int s);
      case (s)
         1:       return WALL_TICKS;
         2:       return PAD_TICKS;
         3:       return SCORE_TICKS;
         default: return 0;
      endcase
   endfunction

   // Drive one clock of inputs, predict the post-edge outputs, compare after the edge.
   task automatic applyStimulus(input logic iRst, input logic iPad, input logic iWall,
                                input logic iScore, input logic iGe);
      logic       wt, pt, tone;
      int         pri;
      logic [3:0] e;
      logic [1:0] sid;
      @(negedge clk);
      wt = cycCnt[1];
      pt = cycCnt[3];
      rst = iRst; pad_hit = iPad; wall_hit = iWall; score_evt = iScore;
      game_en = iGe; wall_tone = wt; pad_tone = pt; mute = muteLvl;
      case (mdlState)
         1:       tone = wt;
         2:       tone = pt;
         3:       tone = (((mdlElapsed / SCORE_SEG) % 2) == 1) ? pt : wt;
         default: tone = 1'b0;
      endcase
      if (iRst) begin
         mdlState = 0; mdlRemain = 0; mdlElapsed = 0;
         e = 4'b0000;
      end else begin
         pri = iScore ? 3 : (iPad ? 2 : (iWall ? 1 : 0));
         if (pri != 0 && pri >= mdlState) begin
            mdlState = pri; mdlRemain = ticksFor(pri); mdlElapsed = 0;
         end else if (iGe && mdlState != 0) begin
            mdlElapsed++;
            mdlRemain--;
            if (mdlRemain == 0) mdlState = 0;
         end
         sid = 2'(mdlState);
         e = {tone & ~muteLvl, (mdlState != 0), sid};
      end
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(curTag, {buzzer, busy, snd_id}, expQ.pop_front());
      cycCnt++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, (phase % 4) == 3);
         phase++;
      end
   endtask

   task automatic fire(input logic p, input logic w, input logic s);
      applyStimulus(1'b0, p, w, s, (phase % 4) == 3);
      phase++;
   endtask

   task automatic pauseCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      curTag = "reset";
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      curTag = "post_reset";
      runCycles(6);

      curTag = "pad_beep";
      fire(1'b1, 1'b0, 1'b0);
      runCycles(PAD_TICKS * 4 + 8);

      curTag = "wall_during_pad";
      fire(1'b1, 1'b0, 1'b0);
      runCycles(9);
      fire(1'b0, 1'b1, 1'b0);
      runCycles(PAD_TICKS * 4);

      curTag = "pad_preempts_wall";
      fire(1'b0, 1'b1, 1'b0);
      runCycles(11);
      fire(1'b1, 1'b0, 1'b0);
      runCycles(PAD_TICKS * 4 + 6);

      curTag = "pad_wall_same";
      fire(1'b1, 1'b1, 1'b0);
      runCycles(PAD_TICKS * 4 + 4);

      curTag = "pad_score_same";
      fire(1'b1, 1'b0, 1'b1);
      runCycles(SCORE_TICKS * 4 + 4);

      curTag = "accept_with_tick";
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      phase = 0;
      runCycles(PAD_TICKS * 4 + 4);

      curTag = "score_mute";
      fire(1'b0, 1'b0, 1'b1);
      runCycles(80);
      muteLvl = 1'b1;
      runCycles(40);
      muteLvl = 1'b0;
      runCycles(SCORE_TICKS * 4);

      curTag = "score_reset";
      fire(1'b0, 1'b0, 1'b1);
      runCycles(16);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      runCycles(8);

      curTag = "pad_pause";
      fire(1'b1, 1'b0, 1'b0);
      runCycles(12);
      pauseCycles(2000);
      runCycles(PAD_TICKS * 4 + 4);

      curTag = "restart_pad";
      fire(1'b1, 1'b0, 1'b0);
      runCycles(10);
      fire(1'b1, 1'b0, 1'b0);
      runCycles(PAD_TICKS * 4 + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
